usbfs_tx_arbiter: RTL and testbench

- Shares the single device-to-host serial byte stream (the devToHost valid/ready/data port of the USB FS serial device) between N independent byte-stream requesters.
- Round-robin arbitration with a burst lock, so one requester's bytes stay contiguous for up to MAX_BURST bytes.
- Sits between on-chip byte sources (debug, logger, ...) and the USB serial transmit endpoint.

---
 rtl/usbfs_tx_arbiter.sv | 119 +++++++++++
 tb/tb_usbfs_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usbfs_tx_arbiter.sv
// Round-robin, burst-locked arbiter sharing the USB FS devToHost byte stream among N_REQ byte sources.
// Optional macro USBFS_TXARB_HEADER_EN inserts a {4'hA, grant} header byte ahead of every burst.
module usbfs_tx_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [N_REQ*8-1:0] i_req_data,
    output logic [N_REQ-1:0]   o_req_ready,
    input  logic               i_devToHost_ready,
    output logic               o_devToHost_valid,
    output logic [7:0]         o_devToHost_data,
    output logic [N_REQ-1:0]   o_grant,
    output logic               o_busy
);
    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

`ifdef USBFS_TXARB_HEADER_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, BURST = 2'd2} state_t;
    localparam state_t GRANT_ST = HDR;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd2} state_t;
    localparam state_t GRANT_ST = BURST;
`endif

    state_t           state, stateNext;
    logic [IDX_W-1:0] grantIdx, grantNext;
    logic [IDX_W-1:0] lastIdx, lastNext;
    logic [IDX_W-1:0] selIdx;
    logic [CNT_W-1:0] burstCnt, cntNext;

    // First requesting lane after the last winner; descending scan lets the nearest one win.
    always_comb begin
        selIdx = lastIdx;
        for (int i = N_REQ; i >= 1; i--) begin
            if (i_req_valid[IDX_W'((int'(lastIdx) + i) % N_REQ)]) begin
                selIdx = IDX_W'((int'(lastIdx) + i) % N_REQ);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            grantIdx <= '0;
            lastIdx  <= IDX_W'(N_REQ - 1);
            burstCnt <= '0;
        end else begin
            state    <= stateNext;
            grantIdx <= grantNext;
            lastIdx  <= lastNext;
            burstCnt <= cntNext;
        end
    end

    always_comb begin
        stateNext         = state;
        grantNext         = grantIdx;
        lastNext          = lastIdx;
        cntNext           = burstCnt;
        o_devToHost_valid = 1'b0;
        o_devToHost_data  = 8'h00;
        o_req_ready       = '0;
        o_busy            = (state != IDLE);
        o_grant           = (state != IDLE) ? (N_REQ'(1) << grantIdx) : '0;

        case (state)
            IDLE: begin
                if (|i_req_valid) begin
                    grantNext = selIdx;
                    lastNext  = selIdx;
                    cntNext   = '0;
                    stateNext = GRANT_ST;
                end
            end
`ifdef USBFS_TXARB_HEADER_EN
            HDR: begin
                o_devToHost_valid = 1'b1;
                o_devToHost_data  = {4'hA, 4'(grantIdx)};
                if (i_devToHost_ready) begin
                    stateNext = BURST;
                end
            end
`endif
            BURST: begin
                o_devToHost_valid     = i_req_valid[grantIdx];
                o_devToHost_data      = i_req_data[{grantIdx, 3'b000} +: 8];
                o_req_ready[grantIdx] = i_devToHost_ready;
                // A drained lane ends the burst without moving a byte.
                if (!i_req_valid[grantIdx]) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (i_devToHost_ready) begin
                    if (burstCnt == CNT_W'(MAX_BURST - 1)) begin
                        stateNext = IDLE;
                        cntNext   = '0;
                    end else begin
                        cntNext = burstCnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

`ifndef SYNTHESIS
    a_grantOnehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(o_grant));
    a_readyUnderGrant: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_req_ready) && ((o_req_ready & ~o_grant) == '0));
    a_validImpliesBusy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !o_devToHost_valid || o_busy);
`endif

endmodule

// File: tb/tb_usbfs_tx_arbiter.sv
// Bench for usbfs_tx_arbiter: per-cycle reference model compared on every negedge, plus directed literal checks.
module tb_usbfs_tx_arbiter;
    localparam int N    = 4;
    localparam int MAXB = 8;
`ifdef USBFS_TXARB_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   i_req_valid;
    logic [N*8-1:0] i_req_data;
    logic [N-1:0]   o_req_ready;
    logic           i_devToHost_ready;
    logic           o_devToHost_valid;
    logic [7:0]     o_devToHost_data;
    logic [N-1:0]   o_grant;
    logic           o_busy;

    usbfs_tx_arbiter #(.N_REQ(N), .MAX_BURST(MAXB)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_req_valid       (i_req_valid),
        .i_req_data        (i_req_data),
        .o_req_ready       (o_req_ready),
        .i_devToHost_ready (i_devToHost_ready),
        .o_devToHost_valid (o_devToHost_valid),
        .o_devToHost_data  (o_devToHost_data),
        .o_grant           (o_grant),
        .o_busy            (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCmp = 0;
    int nErr = 0;

    byte unsigned srcQ[N][$];   // bytes each requester still has to send
    int payLog[$];              // src*256 + byte, in the order requesters saw them accepted
    int dsLog[$];               // every byte that crossed the downstream port
    int grantLog[$];            // each new grant index observed
    logic [N-1:0] hsLat;
    logic [N-1:0] prevGrant;

    // Reference model: granted lane (-1 = idle), bytes sent in burst, last winner, header pending
    int mG = -1;
    int mCnt = 0;
    int mLast = N - 1;
    bit mHdr = 1'b0;

    logic [N-1:0] eGrant, eReady;
    logic         eBusy, eValid;
    logic [7:0]   eData;

    function automatic void chk(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void chkSeq(input string name, input int got[$], input int exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk($sformatf("%s[%0d]", name, i), got[i], exp[i]);
        end
    endfunction

    function automatic void chkPrefix(input string name, input int got[$], input int exp[$]);
        int trimmed[$];
        for (int i = 0; i < exp.size() && i < got.size(); i++) trimmed.push_back(got[i]);
        chkSeq(name, trimmed, exp);
    endfunction

    function automatic int idxOf(input logic [N-1:0] v);
        int r = -1;
        for (int k = N - 1; k >= 0; k--) if (v[k]) r = k;
        return r;
    endfunction

    task automatic refresh();
        for (int k = 0; k < N; k++) begin
            if (srcQ[k].size() > 0) begin
                i_req_valid[k]        = 1'b1;
                i_req_data[k*8 +: 8]  = srcQ[k][0];
            end else begin
                i_req_valid[k]        = 1'b0;
                i_req_data[k*8 +: 8]  = 8'h00;
            end
        end
    endtask

    // Advance one clock; retire bytes that handshook at this edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (hsLat[k] && srcQ[k].size() > 0) begin
                    payLog.push_back(k * 256 + int'(srcQ[k][0]));
                    void'(srcQ[k].pop_front());
                end
            end
        end
        refresh();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic doReset();
        for (int k = 0; k < N; k++) srcQ[k].delete();
        refresh();
        i_devToHost_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_grant", int'(o_grant), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_valid", int'(o_devToHost_valid), 0);
        chk("rst_ready", int'(o_req_ready), 0);
        chk("rst_data", int'(o_devToHost_data), 0);
        tick();
        tick();
        #1 rst_n = 1'b1;
        payLog.delete();
        dsLog.delete();
        grantLog.delete();
    endtask

    // Per-cycle compare against the model, then step the model with this cycle's inputs.
    always @(negedge clk) begin : cmp
        if (!rst_n) begin
            mG = -1; mCnt = 0; mLast = N - 1; mHdr = 1'b0;
            hsLat = '0; prevGrant = '0;
            chk("inrst_grant", int'(o_grant), 0);
            chk("inrst_busy", int'(o_busy), 0);
            chk("inrst_valid", int'(o_devToHost_valid), 0);
        end else begin
            eGrant = '0; eReady = '0; eBusy = 1'b0; eValid = 1'b0; eData = 8'h00;
            if (mG >= 0) begin
                eGrant[mG] = 1'b1;
                eBusy      = 1'b1;
                if (mHdr) begin
                    eValid = 1'b1;
                    eData  = 8'hA0 + 8'(mG);
                end else begin
                    eValid     = i_req_valid[mG];
                    eData      = i_req_data[mG*8 +: 8];
                    eReady[mG] = i_devToHost_ready;
                end
            end
            chk("grant", int'(o_grant), int'(eGrant));
            chk("busy", int'(o_busy), int'(eBusy));
            chk("valid", int'(o_devToHost_valid), int'(eValid));
            chk("data", int'(o_devToHost_data), int'(eData));
            chk("ready", int'(o_req_ready), int'(eReady));

            if (o_devToHost_valid && i_devToHost_ready) dsLog.push_back(int'(o_devToHost_data));
            if (o_grant != '0 && prevGrant == '0) grantLog.push_back(idxOf(o_grant));
            prevGrant = o_grant;
            hsLat     = o_req_ready & i_req_valid;

            if (mG < 0) begin
                for (int i = 1; i <= N; i++) begin
                    if (mG < 0 && i_req_valid[(mLast + i) % N]) mG = (mLast + i) % N;
                end
                if (mG >= 0) begin
                    mLast = mG; mCnt = 0; mHdr = HDR_EN;
                end
            end else if (mHdr) begin
                if (i_devToHost_ready) mHdr = 1'b0;
            end else if (!i_req_valid[mG]) begin
                mG = -1; mCnt = 0;
            end else if (i_devToHost_ready) begin
                mCnt++;
                if (mCnt == MAXB) begin
                    mG = -1; mCnt = 0;
                end
            end
        end
    end

    initial begin
        int expQ[$];
        int waitN;
        bit pat[4];
        rst_n = 1'b0;
        i_req_valid = '0;
        i_req_data = '0;
        i_devToHost_ready = 1'b1;
        hsLat = '0;
        prevGrant = '0;

        // Single requester, three bytes
        doReset();
        srcQ[1] = {8'h11, 8'h22, 8'h33};
        refresh();
        tick();
        chk("t1_grant_1cyc", int'(o_grant), 4'b0010);
        ticks(8);
        chk("t1_idle_busy", int'(o_busy), 0);
        expQ = {32'h111, 32'h122, 32'h133};
        chkSeq("t1_pay", payLog, expQ);
        if (HDR_EN) expQ = {32'hA1, 32'h11, 32'h22, 32'h33};
        else        expQ = {32'h11, 32'h22, 32'h33};
        chkSeq("t1_ds", dsLog, expQ);
        expQ = {32'd1};
        chkSeq("t1_grants", grantLog, expQ);

        // Burst cap with requesters 0 and 2 always valid
        doReset();
        for (int i = 0; i < 20; i++) begin
            srcQ[0].push_back(8'(i));
            srcQ[2].push_back(8'(8'hC0 + i));
        end
        refresh();
        ticks(40);
        expQ = {32'd0, 32'd2, 32'd0};
        chkPrefix("t2_grants", grantLog, expQ);
        expQ.delete();
        for (int i = 0; i < 8; i++) expQ.push_back(i);
        for (int i = 0; i < 8; i++) expQ.push_back(32'h2C0 + i);
        expQ.push_back(32'h008);
        chkPrefix("t2_pay", payLog, expQ);

        // Round-robin wrap with all four requesters valid
        doReset();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 10; i++) srcQ[k].push_back(8'(k * 16 + i));
        refresh();
        ticks(50);
        expQ = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        chkPrefix("t3_grants", grantLog, expQ);

        // Backpressure pattern 1,0,0,1 on a 10-byte stream from requester 1
        doReset();
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) srcQ[1].push_back(8'(8'h40 + i));
        refresh();
        for (int c = 0; c < 40; c++) begin
            i_devToHost_ready = pat[c % 4];
            tick();
        end
        i_devToHost_ready = 1'b1;
        ticks(3);
        expQ = {32'd1, 32'd1};
        chkSeq("t4_grants", grantLog, expQ);
        expQ.delete();
        for (int i = 0; i < 10; i++) expQ.push_back(32'h140 + i);
        chkSeq("t4_pay", payLog, expQ);

        // Drain exit: requester 3 sends two bytes while requester 0 becomes pending
        doReset();
        srcQ[3] = {8'h31, 8'h32};
        refresh();
        tick();
        srcQ[0] = {8'h05};
        refresh();
        ticks(12);
        expQ = {32'd3, 32'd0};
        chkSeq("t5_grants", grantLog, expQ);
        expQ = {32'h331, 32'h332, 32'h005};
        chkSeq("t5_pay", payLog, expQ);

        // Asynchronous reset in the middle of a burst from requester 2
        doReset();
        for (int i = 0; i < 6; i++) srcQ[2].push_back(8'(8'h21 + i));
        refresh();
        waitN = 0;
        while (payLog.size() < 2 && waitN < 20) begin
            tick();
            waitN++;
        end
        chk("t6_wait_two_bytes", int'(payLog.size() >= 2), 1);
        srcQ[0] = {8'h01, 8'h02};
        refresh();
        #2;
        chk("t6_pre_valid", int'(o_devToHost_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(o_devToHost_valid), 0);
        chk("t6_rst_grant", int'(o_grant), 0);
        chk("t6_rst_busy", int'(o_busy), 0);
        tick();
        #1 rst_n = 1'b1;
        payLog.delete();
        dsLog.delete();
        grantLog.delete();
        ticks(30);
        expQ = {32'd0, 32'd2};
        chkSeq("t6_grants", grantLog, expQ);
        expQ = {32'h001, 32'h002, 32'h223, 32'h224, 32'h225, 32'h226};
        chkSeq("t6_pay", payLog, expQ);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
